// File: rtl/shell_pkg.sv
// shell_pkg: ASCII constants, FSM states and hex helpers for the UART shell.
// Shared by uart_rx and uart_shell.
package shell_pkg;

  localparam int LINE_LEN = 16;
  localparam int DEF_CLKS_PER_BIT = 868;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_QM = 8'h3F;
  localparam logic [7:0] CH_GT = 8'h3E;

  typedef enum logic [1:0] {IDLE, ECHO, EXEC, REPLY} state_t;
  typedef enum logic [2:0] {
    C_NONE, C_BAD, C_GET, C_READ, C_WRITE
  } cmd_t;

  // bit 4 flags a valid hex digit, bits 3:0 carry its value
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= "0" && c <= "9")
      r = {1'b1, 4'(c - 8'h30)};
    else if (c >= "A" && c <= "F")
      r = {1'b1, 4'(c - 8'h37)};
    else if (c >= "a" && c <= "f")
      r = {1'b1, 4'(c - 8'h57)};
    return r;
  endfunction

  function automatic logic [7:0] hex_enc(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n}
                       : 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop synchronizer and mid-bit sampling.
// Emits a one-cycle valid strobe per accepted byte.
module uart_rx
  import shell_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       valid,
  output logic [7:0] data
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_state_t;

  rx_state_t   st;
  logic [2:0]  sync;
  logic [CW-1:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  sh;
  logic        rxs;

  // sync[1] is the synchronized line, sync[2] its previous value
  assign rxs = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 3'b111;
      st    <= R_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      valid <= 1'b0;
      data  <= '0;
    end else begin
      sync  <= {sync[1:0], rx};
      valid <= 1'b0;
      unique case (st)
        R_IDLE: begin
          cnt <= '0;
          if (sync[2] && !rxs) st <= R_START;
        end
        R_START: begin
          if (cnt == HALF_END) begin
            cnt <= '0;
            idx <= '0;
            st  <= rxs ? R_IDLE : R_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            sh  <= {rxs, sh[7:1]};
            idx <= idx + 1'b1;
            if (idx == 3'd7) st <= R_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            st  <= R_IDLE;
            if (rxs) begin
              valid <= 1'b1;
              data  <= sh;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_shell.sv
// uart_shell: line-editing command shell (g / r / w) over an 8N1 UART.
// Define SHELL_ECHO_EN to echo received characters back to the sender.
module uart_shell
  import shell_pkg::*;
#(
  parameter int         CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter logic [7:0] BUILD_ID     = 8'h37
) (
  input  logic CLK,
  input  logic RST,
  input  logic UART_RX,
  output logic UART_TX
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);

  logic       rx_valid;
  logic [7:0] rx_data;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk   (CLK),
    .rst_n (RST),
    .rx    (UART_RX),
    .valid (rx_valid),
    .data  (rx_data)
  );

  logic          tx_go;
  logic          tx_busy;
  logic [7:0]    tx_byte;
  logic [8:0]    tx_sh;
  logic [3:0]    tx_bit;
  logic [CW-1:0] tx_cnt;

  // tx_bit 0 is the start bit, 1..8 data, 9 stop
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      UART_TX <= 1'b1;
      tx_busy <= 1'b0;
      tx_sh   <= '1;
      tx_bit  <= '0;
      tx_cnt  <= '0;
    end else if (tx_go && !tx_busy) begin
      UART_TX <= 1'b0;
      tx_sh   <= {1'b1, tx_byte};
      tx_bit  <= '0;
      tx_cnt  <= '0;
      tx_busy <= 1'b1;
    end else if (tx_busy) begin
      if (tx_cnt == BIT_END) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          UART_TX <= tx_sh[0];
          tx_sh   <= {1'b1, tx_sh[8:1]};
          tx_bit  <= tx_bit + 1'b1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  state_t      st;
  logic        ph;
  logic        go_exec;
  logic        ovf;
  logic [4:0]  len;
  logic [4:0]  elen;
  logic [7:0]  lbuf [LINE_LEN];
  logic [7:0]  rq [8];
  logic [3:0]  rlen;
  logic [3:0]  ridx;
  logic [4:0]  dig [11];
  logic        a_ok;
  logic        d_ok;
  logic        printable;
  cmd_t        cmd;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [15:0] mem [256];
  logic [7:0]  nq [8];
  logic [3:0]  nlen;

  assign printable = (rx_data >= 8'h20) && (rx_data <= 8'h7E);

  always_comb begin
    elen = len;
    // strip trailing spaces from the end inward
    for (int i = LINE_LEN - 1; i >= 0; i--)
      if (elen == 5'(i + 1) && lbuf[i] == CH_SP)
        elen = 5'(i);
    for (int i = 0; i < 11; i++)
      dig[i] = hex_dec(lbuf[i]);
    addr  = {dig[4][3:0], dig[5][3:0]};
    wdata = {dig[7][3:0], dig[8][3:0],
             dig[9][3:0], dig[10][3:0]};
    a_ok  = (lbuf[1] == CH_SP) && dig[2][4] && dig[3][4]
            && dig[4][4] && dig[5][4];
    d_ok  = (lbuf[6] == CH_SP) && dig[7][4] && dig[8][4]
            && dig[9][4] && dig[10][4];
    if (ovf)
      cmd = C_BAD;
    else if (elen == 5'd0)
      cmd = C_NONE;
    else if (elen == 5'd1 && lbuf[0] == "g")
      cmd = C_GET;
    else if (elen == 5'd6 && lbuf[0] == "r" && a_ok)
      cmd = C_READ;
    else if (elen == 5'd11 && lbuf[0] == "w" && a_ok && d_ok)
      cmd = C_WRITE;
    else
      cmd = C_BAD;
  end

  always_ff @(posedge CLK) begin
    if (st == EXEC && !ph && cmd == C_WRITE)
      mem[addr] <= wdata;
    rdata <= mem[addr];
  end

  // every reply ends in the "> " prompt; unset slots default to space
  always_comb begin
    for (int i = 0; i < 8; i++)
      nq[i] = CH_SP;
    nlen = 4'd5;
    unique case (cmd)
      C_NONE: begin
        nq[0] = CH_GT;
        nlen  = 4'd2;
      end
      C_GET: begin
        nq[0] = BUILD_ID;
        nq[1] = CH_CR;
        nq[2] = CH_LF;
        nq[3] = CH_GT;
      end
      C_READ: begin
        nq[0] = hex_enc(rdata[15:12]);
        nq[1] = hex_enc(rdata[11:8]);
        nq[2] = hex_enc(rdata[7:4]);
        nq[3] = hex_enc(rdata[3:0]);
        nq[4] = CH_CR;
        nq[5] = CH_LF;
        nq[6] = CH_GT;
        nlen  = 4'd8;
      end
      C_WRITE: begin
        nq[0] = "O";
        nq[1] = "K";
        nq[2] = CH_CR;
        nq[3] = CH_LF;
        nq[4] = CH_GT;
        nlen  = 4'd6;
      end
      default: begin
        nq[0] = CH_QM;
        nq[1] = CH_CR;
        nq[2] = CH_LF;
        nq[3] = CH_GT;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st      <= IDLE;
      ph      <= 1'b0;
      go_exec <= 1'b0;
      ovf     <= 1'b0;
      len     <= '0;
      rlen    <= '0;
      ridx    <= '0;
      tx_go   <= 1'b0;
      tx_byte <= '0;
      for (int i = 0; i < LINE_LEN; i++) lbuf[i] <= '0;
      for (int i = 0; i < 8; i++) rq[i] <= '0;
    end else begin
      tx_go <= 1'b0;
      unique case (st)
        IDLE: if (rx_valid) begin
          ridx <= '0;
          if (printable) begin
            if (len == 5'(LINE_LEN)) begin
              ovf <= 1'b1;
            end else begin
              lbuf[len[3:0]] <= rx_data;
              len <= len + 1'b1;
`ifdef SHELL_ECHO_EN
              rq[0] <= rx_data;
              rlen  <= 4'd1;
              st    <= ECHO;
`endif
            end
          end else if (rx_data == CH_BS) begin
            if (len != 5'd0) len <= len - 1'b1;
`ifdef SHELL_ECHO_EN
            rq[0] <= CH_BS;
            rlen  <= 4'd1;
            st    <= ECHO;
`endif
          end else if (rx_data == CH_CR) begin
            ph <= 1'b0;
`ifdef SHELL_ECHO_EN
            rq[0]   <= CH_CR;
            rq[1]   <= CH_LF;
            rlen    <= 4'd2;
            go_exec <= 1'b1;
            st      <= ECHO;
`else
            st <= EXEC;
`endif
          end
        end
        ECHO, REPLY: if (!tx_go && !tx_busy) begin
          if (ridx == rlen) begin
            if (st == REPLY) begin
              len <= '0;
              ovf <= 1'b0;
              st  <= IDLE;
            end else begin
              go_exec <= 1'b0;
              st      <= go_exec ? EXEC : IDLE;
            end
          end else begin
            tx_go   <= 1'b1;
            tx_byte <= rq[ridx[2:0]];
            ridx    <= ridx + 1'b1;
          end
        end
        EXEC: begin
          // phase 0 writes/reads RAM, phase 1 latches the reply
          if (!ph) begin
            ph <= 1'b1;
          end else begin
            for (int i = 0; i < 8; i++) rq[i] <= nq[i];
            rlen <= nlen;
            ridx <= '0;
            st   <= REPLY;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_shell.sv
// tb_uart_shell: directed command-line vectors and reset/glitch sequences
// for uart_shell, checked against hand-written reply strings.
module tb_uart_shell;

  localparam int CPB = 8;
`ifdef SHELL_ECHO_EN
  localparam bit ECHO_ON = 1'b1;
`else
  localparam bit ECHO_ON = 1'b0;
`endif
  localparam int GAP = ECHO_ON ? 11 * CPB : CPB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx = 1'b1;
  logic tx;

  uart_shell #(
    .CLKS_PER_BIT (CPB),
    .BUILD_ID     (8'h37)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .UART_RX (rx),
    .UART_TX (tx)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] txq[$];

  int m_cnt = 0;
  bit m_busy = 1'b0;
  logic [7:0] m_sh = '0;

  always @(negedge clk) begin
    if (!rst) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (tx === 1'b0) begin
        m_busy = 1'b1;
        m_cnt = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt % CPB == CPB / 2) begin
        if (m_cnt / CPB == 9) begin
          txq.push_back(m_sh);
          m_busy = 1'b0;
          if (tx !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL tx_stop: got %b want 1", tx);
          end
        end else if (m_cnt / CPB >= 1) begin
          m_sh = {tx, m_sh[7:1]};
        end
      end
    end
  end

  typedef struct {
    string name;
    string line;
    string reply;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(input string n, input string l,
                              input string r);
    vec_t v;
    v.name = n;
    v.line = l;
    v.reply = r;
    return v;
  endfunction

  function automatic string hexs(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++)
      r = {r, $sformatf("%02h", s[i])};
    return r;
  endfunction

  function automatic string line_exp(input string echo_s,
                                     input string reply);
    string e;
    e = "";
    if (ECHO_ON) e = {echo_s, "\015\012"};
    return {e, reply, "> "};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = f[i];
      repeat (CPB - 1) @(negedge clk);
    end
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic expect_tx(input string name, input string exp);
    int n;
    string got;
    n = 0;
    while (txq.size() < exp.len() && n < (exp.len() + 2) * 12 * CPB) begin
      @(negedge clk);
      n++;
    end
    repeat (12 * CPB) @(negedge clk);
    got = "";
    while (txq.size() > 0)
      got = {got, $sformatf("%02h", txq.pop_front())};
    tests++;
    if (got != hexs(exp)) begin
      fails++;
      $display("FAIL %s: got %s want %s", name, got, hexs(exp));
    end
  endtask

  task automatic run_line(input string name, input string line,
                          input string echo_s, input string reply);
    send_str(line);
    send_byte(8'h0D);
    expect_tx(name, line_exp(echo_s, reply));
  endtask

  task automatic check_bit(input string name, input logic got,
                           input logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  initial begin
    string ov;
    string ov16;
    int n;

    vt[0]  = mk("get",        "g",            "7\015\012");
    vt[1]  = mk("write11",    "w 0011 1111",  "OK\015\012");
    vt[2]  = mk("read11",     "r 0011",       "1111\015\012");
    vt[3]  = mk("unknown",    "x",            "?\015\012");
    vt[4]  = mk("write_ab",   "w 00ab BEEF",  "OK\015\012");
    vt[5]  = mk("read_hiad",  "r 12AB",       "BEEF\015\012");
    vt[6]  = mk("read_trail", "r 00aB  ",     "BEEF\015\012");
    vt[7]  = mk("empty",      "",             "");
    vt[8]  = mk("two_space",  "r  0011",      "?\015\012");
    vt[9]  = mk("short_hex",  "r 011",        "?\015\012");
    vt[10] = mk("write_34",   "w 5534 abcd",  "OK\015\012");
    vt[11] = mk("read_34",    "r 0034",       "ABCD\015\012");
    vt[12] = mk("bad_hex",    "r 0g11",       "?\015\012");
    vt[13] = mk("upper_g",    "G",            "?\015\012");
    vt[14] = mk("get_trail",  "g ",           "7\015\012");
    vt[15] = mk("short_data", "w 0011 111",   "?\015\012");
    vt[16] = mk("read11_kept","r 0011",       "1111\015\012");

    rst = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check_bit("reset_tx", tx, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    tests++;
    if (txq.size() != 0) begin
      fails++;
      $display("FAIL reset_quiet: got %0d bytes want 0", txq.size());
    end

    for (int i = 0; i < 17; i++)
      run_line(vt[i].name, vt[i].line, vt[i].line, vt[i].reply);

    run_line("backspace", "r 0a\010\01000AB",
             "r 0a\010\01000AB", "BEEF\015\012");
    run_line("bs_empty", "\010g", "\010g", "7\015\012");
    run_line("nonprint", "\001g", "g", "7\015\012");

    ov = "";
    for (int i = 0; i < 17; i++) ov = {ov, "a"};
    ov16 = ov.substr(0, 15);
    run_line("overflow", ov, ov16, "?\015\012");
    run_line("after_ovf", "g", "g", "7\015\012");

    @(negedge clk);
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    tests++;
    if (txq.size() != 0) begin
      fails++;
      $display("FAIL glitch_quiet: got %0d bytes want 0", txq.size());
    end
    run_line("after_glitch", "g", "g", "7\015\012");

    send_str("g");
    send_byte(8'h0D);
    n = 0;
    while (txq.size() < (ECHO_ON ? 4 : 1) && n < 60 * CPB) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (tx !== 1'b0 && n < 4 * CPB) begin
      @(negedge clk);
      n++;
    end
    repeat (CPB / 2) @(negedge clk);
    check_bit("rst_pre_low", tx, 1'b0);
    rst = 1'b0;
    #1;
    check_bit("rst_tx_async", tx, 1'b1);
    repeat (4) @(negedge clk);
    check_bit("rst_tx_hold", tx, 1'b1);
    rst = 1'b1;
    txq.delete();
    repeat (30 * CPB) @(negedge clk);
    tests++;
    if (txq.size() != 0) begin
      fails++;
      $display("FAIL no_prompt: got %0d bytes want 0", txq.size());
    end
    run_line("after_rst", "g", "g", "7\015\012");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
